// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage hazard and bypass controller.
// Generates EX/ME operand bypass selects and the load-use stall. It also
// tracks one in-flight multi-cycle MUL/DIV operation in a scoreboard with a
// fixed latency, so that later instructions only wait when they depend on it.
// Optional feature macro: HZD_PERF_CNT_EN adds stall_cycles and
// md_stall_cycles performance counters.
module id_hazard_ctrl #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int MD_LAT = 4,
  localparam int AW    = $clog2(NREG),
  localparam int CW    = $clog2(MD_LAT + 1)
) (
  input  logic          clock,
  input  logic          reset_0,
  input  logic          id_valid,
  input  logic          flush,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic          use_rs,
  input  logic          use_rt,
  input  logic          id_wreg,
  input  logic [AW-1:0] id_rw,
  input  logic          id_md,
  input  logic          wreg_ex,
  input  logic          m2reg_ex,
  input  logic [AW-1:0] rw_ex,
  input  logic          wreg_me,
  input  logic          m2reg_me,
  input  logic [AW-1:0] rw_me,
  output logic [1:0]    a_select,
  output logic [1:0]    b_select,
  output logic          stall,
  output logic          issue,
  output logic          md_busy,
  output logic [AW-1:0] md_rw,
  output logic          md_wb
`ifdef HZD_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] stall_cycles,
  output logic [XLEN-1:0] md_stall_cycles
`endif
);

  // A MUL/DIV latency below 2 leaves no room for the writeback cycle.
  if (MD_LAT < 2 || XLEN < 1) begin : g_bad_param
    $error("id_hazard_ctrl: MD_LAT must be >= 2 and XLEN >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  md_state_t     state_q, state_d;
  logic [CW-1:0] md_cnt, cnt_d;
  logic [AW-1:0] rw_d;
  logic          id_live;
  logic          md_start;
  logic          load_use;
  logic          md_raw;
  logic          md_waw;
  logic          md_struct;
  logic          md_hazard;

  // Select a bypass source for one operand; EX beats ME and r0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] src,
    input logic          w_ex,
    input logic          ld_ex,
    input logic [AW-1:0] d_ex,
    input logic          w_me,
    input logic          ld_me,
    input logic [AW-1:0] d_me
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (w_ex && (d_ex == src) && (d_ex != '0) && !ld_ex) begin
      sel = 2'b01;
    end else if (w_me && (d_me == src) && (d_me != '0)) begin
      sel = ld_me ? 2'b11 : 2'b10;
    end
    return sel;
  endfunction

  // Operand bypass selects, purely combinational from the EX/ME destinations.
  always_comb begin
    a_select = fwd_sel(rs, wreg_ex, m2reg_ex, rw_ex, wreg_me, m2reg_me, rw_me);
    b_select = fwd_sel(rt, wreg_ex, m2reg_ex, rw_ex, wreg_me, m2reg_me, rw_me);
  end

  // Hazard terms; a squashed or empty ID slot never stalls.
  always_comb begin
    id_live   = id_valid & ~flush;
    load_use  = wreg_ex & m2reg_ex & (rw_ex != '0) &
                ((use_rs & (rw_ex == rs)) | (use_rt & (rw_ex == rt)));
    md_raw    = md_busy & (md_rw != '0) &
                ((use_rs & (rs == md_rw)) | (use_rt & (rt == md_rw)));
    md_waw    = md_busy & id_wreg & (id_rw == md_rw) & (md_rw != '0);
    md_struct = md_busy & id_md & ~md_wb;
    md_hazard = md_raw | md_waw | md_struct;
    stall     = id_live & (load_use | md_hazard);
    issue     = id_live & ~stall;
    md_start  = issue & id_md;
  end

  // Scoreboard status decoded from the countdown.
  always_comb begin
    md_busy = (md_cnt != '0);
    md_wb   = (md_cnt == CW'(1));
  end

  // Scoreboard next state: load on MUL/DIV issue, count down, reload on the
  // writeback cycle so back-to-back MUL/DIV flows without a gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = md_cnt;
    rw_d    = md_rw;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = CW'(MD_LAT);
          rw_d    = id_rw;
        end
      end
      BUSY: begin
        if (md_wb) begin
          if (md_start) begin
            cnt_d = CW'(MD_LAT);
            rw_d  = id_rw;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = md_cnt - CW'(1);
        end
      end
    endcase
  end

  // Scoreboard registers; reset drops any in-flight MUL/DIV silently.
  always_ff @(posedge clock) begin
    if (reset_0) begin
      state_q <= IDLE;
      md_cnt  <= '0;
      md_rw   <= '0;
    end else begin
      state_q <= state_d;
      md_cnt  <= cnt_d;
      md_rw   <= rw_d;
    end
  end

`ifdef HZD_PERF_CNT_EN
  // Free-running wrap-around counters of total and MUL/DIV-caused stalls.
  always_ff @(posedge clock) begin
    if (reset_0) begin
      stall_cycles    <= '0;
      md_stall_cycles <= '0;
    end else begin
      if (stall) begin
        stall_cycles <= stall_cycles + XLEN'(1);
      end
      if (id_live && md_hazard) begin
        md_stall_cycles <= md_stall_cycles + XLEN'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed scoreboard bench for id_hazard_ctrl
// (default parameters: NREG=32, MD_LAT=4).
module tb_id_hazard_ctrl;

  typedef struct packed {
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic       stall;
    logic       issue;
    logic       busy;
    logic [4:0] rw;
    logic       wb;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_0;
  logic       id_valid, flush;
  logic [4:0] rs, rt;
  logic       use_rs, use_rt;
  logic       id_wreg;
  logic [4:0] id_rw;
  logic       id_md;
  logic       wreg_ex, m2reg_ex;
  logic [4:0] rw_ex;
  logic       wreg_me, m2reg_me;
  logic [4:0] rw_me;
  logic [1:0] a_select, b_select;
  logic       stall, issue, md_busy, md_wb;
  logic [4:0] md_rw;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;

  id_hazard_ctrl dut (
    .clock    (clock),
    .reset_0  (reset_0),
    .id_valid (id_valid),
    .flush    (flush),
    .rs       (rs),
    .rt       (rt),
    .use_rs   (use_rs),
    .use_rt   (use_rt),
    .id_wreg  (id_wreg),
    .id_rw    (id_rw),
    .id_md    (id_md),
    .wreg_ex  (wreg_ex),
    .m2reg_ex (m2reg_ex),
    .rw_ex    (rw_ex),
    .wreg_me  (wreg_me),
    .m2reg_me (m2reg_me),
    .rw_me    (rw_me),
    .a_select (a_select),
    .b_select (b_select),
    .stall    (stall),
    .issue    (issue),
    .md_busy  (md_busy),
    .md_rw    (md_rw),
    .md_wb    (md_wb)
  );

  // 10-time-unit clock.
  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [1:0] a, input logic [1:0] b,
                              input logic st, input logic is, input logic bz,
                              input logic [4:0] rw, input logic wb);
    exp_t e;
    e.a_sel = a; e.b_sel = b; e.stall = st; e.issue = is;
    e.busy = bz; e.rw = rw; e.wb = wb;
    return e;
  endfunction

  task automatic checkOutput(input string name, input string field,
                             input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s.%s: got %0h expected %0h", name, field, act, req);
    end
  endtask

  // Monitor: mid-cycle, pop the expectation issued for this cycle and compare.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checkOutput(n, "a_select", {6'd0, a_select}, {6'd0, e.a_sel});
      checkOutput(n, "b_select", {6'd0, b_select}, {6'd0, e.b_sel});
      checkOutput(n, "stall",    {7'd0, stall},    {7'd0, e.stall});
      checkOutput(n, "issue",    {7'd0, issue},    {7'd0, e.issue});
      checkOutput(n, "md_busy",  {7'd0, md_busy},  {7'd0, e.busy});
      checkOutput(n, "md_rw",    {3'd0, md_rw},    {3'd0, e.rw});
      checkOutput(n, "md_wb",    {7'd0, md_wb},    {7'd0, e.wb});
    end
  end

  task automatic clear_inputs();
    id_valid = 0; flush = 0; rs = 0; rt = 0; use_rs = 0; use_rt = 0;
    id_wreg = 0; id_rw = 0; id_md = 0;
    wreg_ex = 0; m2reg_ex = 0; rw_ex = 0;
    wreg_me = 0; m2reg_me = 0; rw_me = 0;
  endtask

  // Inputs are already set for this cycle; queue the expectation and advance.
  task automatic applyStimulus(input string name, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle(input string name, input exp_t e);
    clear_inputs();
    applyStimulus(name, e);
  endtask

  // Runaway guard.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    reset_0 = 1;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1;
    reset_0 = 0;

    idle_cycle("reset_idle", mk(2'b00, 2'b00, 0, 0, 0, 5'd0, 0));

    clear_inputs(); id_valid = 1; rs = 5; use_rs = 1; wreg_ex = 1; rw_ex = 5;
    applyStimulus("alu_fwd_ex", mk(2'b01, 2'b00, 0, 1, 0, 5'd0, 0));
    wreg_me = 1; rw_me = 5;
    applyStimulus("ex_over_me", mk(2'b01, 2'b00, 0, 1, 0, 5'd0, 0));
    clear_inputs(); id_valid = 1; rs = 5; use_rs = 1; wreg_me = 1; rw_me = 5;
    applyStimulus("me_alu_fwd", mk(2'b10, 2'b00, 0, 1, 0, 5'd0, 0));
    clear_inputs(); id_valid = 1; rt = 7; use_rt = 1; wreg_me = 1; m2reg_me = 1; rw_me = 7;
    applyStimulus("me_load_b", mk(2'b00, 2'b11, 0, 1, 0, 5'd0, 0));

    clear_inputs(); id_valid = 1; rt = 8; use_rt = 1; wreg_ex = 1; m2reg_ex = 1; rw_ex = 8;
    applyStimulus("load_use", mk(2'b00, 2'b00, 1, 0, 0, 5'd0, 0));
    clear_inputs(); id_valid = 1; rt = 8; use_rt = 1; wreg_me = 1; m2reg_me = 1; rw_me = 8;
    applyStimulus("load_in_me", mk(2'b00, 2'b11, 0, 1, 0, 5'd0, 0));

    clear_inputs(); id_valid = 1; rs = 0; use_rs = 1; wreg_ex = 1; m2reg_ex = 1; rw_ex = 0;
    applyStimulus("reg0_no_hazard", mk(2'b00, 2'b00, 0, 1, 0, 5'd0, 0));
    clear_inputs(); id_valid = 1; rs = 8; use_rs = 0; wreg_ex = 1; m2reg_ex = 1; rw_ex = 8;
    applyStimulus("unused_src", mk(2'b00, 2'b00, 0, 1, 0, 5'd0, 0));

    // MUL to r9 followed by a dependent read.
    clear_inputs(); id_valid = 1; id_md = 1; id_wreg = 1; id_rw = 9;
    applyStimulus("mul_r9", mk(2'b00, 2'b00, 0, 1, 0, 5'd0, 0));
    clear_inputs(); id_valid = 1; rs = 9; use_rs = 1; id_wreg = 1; id_rw = 10;
    for (int c = 1; c <= 3; c++)
      applyStimulus("raw_wait", mk(2'b00, 2'b00, 1, 0, 1, 5'd9, 0));
    applyStimulus("raw_wb", mk(2'b00, 2'b00, 1, 0, 1, 5'd9, 1));
    applyStimulus("raw_issue", mk(2'b00, 2'b00, 0, 1, 0, 5'd9, 0));

    // Back-to-back MUL: second waits for the writeback cycle.
    clear_inputs(); id_valid = 1; id_md = 1; id_wreg = 1; id_rw = 11;
    applyStimulus("mul_a", mk(2'b00, 2'b00, 0, 1, 0, 5'd9, 0));
    id_rw = 12;
    for (int c = 1; c <= 3; c++)
      applyStimulus("mul_b_struct", mk(2'b00, 2'b00, 1, 0, 1, 5'd11, 0));
    applyStimulus("mul_b_issue", mk(2'b00, 2'b00, 0, 1, 1, 5'd11, 1));
    for (int c = 5; c <= 7; c++)
      idle_cycle("mul_b_busy", mk(2'b00, 2'b00, 0, 0, 1, 5'd12, 0));
    idle_cycle("mul_b_wb", mk(2'b00, 2'b00, 0, 0, 1, 5'd12, 1));
    idle_cycle("mul_b_done", mk(2'b00, 2'b00, 0, 0, 0, 5'd12, 0));

    // A flushed MUL never reaches the scoreboard.
    clear_inputs(); id_valid = 1; id_md = 1; id_wreg = 1; id_rw = 14; flush = 1;
    applyStimulus("mul_flushed", mk(2'b00, 2'b00, 0, 0, 0, 5'd12, 0));
    idle_cycle("mul_flushed_idle", mk(2'b00, 2'b00, 0, 0, 0, 5'd12, 0));

    // MUL to r0 creates no RAW/WAW hazard.
    clear_inputs(); id_valid = 1; id_md = 1; id_wreg = 1; id_rw = 0;
    applyStimulus("mul_r0", mk(2'b00, 2'b00, 0, 1, 0, 5'd12, 0));
    clear_inputs(); id_valid = 1; rs = 0; use_rs = 1; id_wreg = 1; id_rw = 0;
    applyStimulus("r0_dep", mk(2'b00, 2'b00, 0, 1, 1, 5'd0, 0));
    idle_cycle("r0_busy", mk(2'b00, 2'b00, 0, 0, 1, 5'd0, 0));
    idle_cycle("r0_busy", mk(2'b00, 2'b00, 0, 0, 1, 5'd0, 0));
    idle_cycle("r0_wb", mk(2'b00, 2'b00, 0, 0, 1, 5'd0, 1));
    idle_cycle("r0_done", mk(2'b00, 2'b00, 0, 0, 0, 5'd0, 0));

    // WAW stall, then flush + reset in cycle 2 of the MUL.
    clear_inputs(); id_valid = 1; id_md = 1; id_wreg = 1; id_rw = 13;
    applyStimulus("mul_r13", mk(2'b00, 2'b00, 0, 1, 0, 5'd0, 0));
    clear_inputs(); id_valid = 1; id_wreg = 1; id_rw = 13;
    applyStimulus("waw_stall", mk(2'b00, 2'b00, 1, 0, 1, 5'd13, 0));
    clear_inputs(); id_valid = 1; rs = 13; use_rs = 1; flush = 1; reset_0 = 1;
    applyStimulus("flush_raw", mk(2'b00, 2'b00, 0, 0, 1, 5'd13, 0));
    reset_0 = 0;
    idle_cycle("reset_drop", mk(2'b00, 2'b00, 0, 0, 0, 5'd0, 0));
    idle_cycle("no_wb_pulse", mk(2'b00, 2'b00, 0, 0, 0, 5'd0, 0));
    idle_cycle("no_wb_pulse", mk(2'b00, 2'b00, 0, 0, 0, 5'd0, 0));

    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Parametrised hazard and bypass controller for the ID stage of the 5-stage pipeline CPU.
- Generates the same EX/ME bypass selects and load-use stall as the current decode-stage controller, for generic register-file width and depth.
- Adds a scoreboard for one in-flight multi-cycle MUL/DIV operation (ALU codes 1000/1100) with programmable latency, so that long operations retire without blocking the pipeline.
- Sits between the ID decoder outputs and the ID/EX register, and drives the PC-hold/bubble logic.

## Interface
Parameters:
- XLEN, 32, datapath width (used only by the optional counter).
- NREG, 32, register count; AW = $clog2(NREG) is the register-index width.
- MD_LAT, 4, MUL/DIV latency in cycles (≥2). CW = $clog2(MD_LAT+1).

Ports (one clock; reset is synchronous, active-high):
- clock  in  1  rising-edge clock
- reset_0  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a valid instruction
- flush  in  1  ID instruction is being squashed (taken branch/jump)
- rs, rt  in  AW each  source register indices
- use_rs, use_rt  in  1 each  instruction actually reads rs / rt
- id_wreg  in  1  ID instruction writes a register
- id_rw  in  AW  ID destination register
- id_md  in  1  ID instruction is MUL/DIV
- wreg_ex, m2reg_ex  in  1 each  EX writes a register / EX is a load
- rw_ex  in  AW  EX destination register
- wreg_me, m2reg_me  in  1 each  same for ME
- rw_me  in  AW  ME destination register
- a_select, b_select  out  2 each  00 regfile, 01 ans_ex, 10 ans_me, 11 mo_me
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
- issue  out  1  id_valid & ~stall & ~flush
- md_busy  out  1  MUL/DIV scoreboard occupied
- md_rw  out  AW  destination of the in-flight MUL/DIV
- md_wb  out  1  one-cycle MUL/DIV writeback strobe

## Operation
Bypass (combinational):
- Operand a (rs): 01 if wreg_ex & rw_ex==rs & rw_ex≠0 & ~m2reg_ex.
- Else 10 if the ME match holds with ~m2reg_me.
- Else 11 if the ME match holds with m2reg_me.
- Else 00. Operand b (rt) uses the identical rules.
- EX always has priority over ME. Register 0 never forwards and never stalls.

Stall (combinational, OR of the following terms, each gated by id_valid & ~flush):
- Load-use: wreg_ex & m2reg_ex & rw_ex≠0 & ((use_rs & rw_ex==rs) | (use_rt & rw_ex==rt)).
- MD RAW: md_busy & md_rw≠0 & ((use_rs & rs==md_rw) | (use_rt & rt==md_rw)).
- MD WAW: md_busy & id_wreg & id_rw==md_rw & md_rw≠0.
- MD structural: md_busy & id_md & ~md_wb.

Scoreboard (registered):
- States: IDLE (md_cnt==0) and BUSY (md_cnt>0).
- IDLE→BUSY on issue & id_md: md_cnt←MD_LAT, md_rw←id_rw.
- BUSY: md_cnt decrements each cycle. md_wb = (md_cnt==1).
- On the md_wb cycle, issue & id_md reloads md_cnt←MD_LAT and md_rw←id_rw (back-to-back MUL/DIV allowed). Otherwise md_cnt reaches 0 and the scoreboard returns to IDLE.
- md_busy = (md_cnt≠0). RAW/WAW stalls still apply during the md_wb cycle.

## Timing
- Reset: md_cnt=0, md_rw=0, md_busy=0, md_wb=0. With no inputs active, stall=0 and selects=00.
- Reset mid-operation discards the in-flight MUL/DIV with no md_wb pulse.
- Bypass and stall outputs have zero latency from inputs and current scoreboard state.
- MUL/DIV issue sampled at the edge ending cycle 0:
  - md_busy is high in cycles 1..MD_LAT.
  - md_wb is high in cycle MD_LAT only.
  - A RAW-dependent instruction issues in cycle MD_LAT+1 at the earliest.
- Load-use stall lasts exactly one cycle. The next cycle the load is in ME and the operand select is 11.
- flush has priority over stall: stall=0 and issue=0. The scoreboard is unaffected by flush.

## Configuration
- HZD_PERF_CNT_EN defined: adds two outputs.
  - stall_cycles [XLEN-1:0]: increments every cycle stall=1, wraps at 2^XLEN.
  - md_stall_cycles [XLEN-1:0]: increments only on MD-caused stalls.
  - Both reset to 0 on reset_0.
- HZD_PERF_CNT_EN undefined: neither port nor its counter exists. All other behaviour is identical.

## Test plan
- ALU write then dependent read: EX wreg_ex=1, rw_ex=5; ID rs=5, use_rs=1 → a_select=01, stall=0. With the same rw_me=5 in ME also present → a_select remains 01.
- Load-use: m2reg_ex=1, rw_ex=8; ID rt=8, use_rt=1 → stall=1 for 1 cycle. Next cycle, with load in ME → b_select=11, stall=0.
- Register 0: rw_ex=0, wreg_ex=1, m2reg_ex=1, rs=0 → a_select=00, stall=0.
- MUL to r9 (MD_LAT=4), next instruction reads r9 → stall in cycles 1–4, md_wb in cycle 4 only, issue in cycle 5.
- Back-to-back MUL: second MUL waits until cycle 4, issues with md_wb=1 → md_busy stays 1 through cycle 8 and md_rw switches to the new rd.
- Reset at cycle 2 of a MUL → md_busy=0 next cycle, no md_wb pulse. Flush during a RAW stall → stall=0, issue=0.
